scan_reg_bank: RTL and testbench
================================

# scan_reg_bank

Parametrised scan register bank for the scan-inserted benchmark netlists. It is the multi-bit, multi-chain successor to the single-bit scan flop `sdffs1`. It holds WIDTH functional bits split into CHAINS equal scan segments, with capture, hold and shift modes. A shadow update register drives a stable functional output, and a shift counter flags when every segment has been fully unloaded and reloaded.

## Interface
- WIDTH, 16, total register bits; must be a multiple of CHAINS.
- CHAINS, 2, number of independent scan segments.
- RST_VAL, '0, WIDTH-bit reset value of the capture register and the shadow register.
- Derived: L = WIDTH/CHAINS (segment length); CW = $clog2(L+1).

Ports:
- CLK  in  1  clock, rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- DIN  in  WIDTH  functional capture data.
- SDIN  in  CHAINS  scan-in, one bit per segment.
- SSEL  in  1  scan shift enable.
- HOLD  in  1  hold capture register (functional mode only).
- UPD  in  1  load shadow register from capture register.
- Q  out  WIDTH  shadow register.
- QN  out  WIDTH  ~Q.
- SDOUT  out  CHAINS  scan-out, one bit per segment.
- SHIFT_CNT  out  CW  consecutive shift cycles, saturating at L.
- SDONE  out  1  one-cycle pulse: L consecutive shifts completed.

## Operation
- Internal capture register R[WIDTH-1:0]. Segment c owns R[c*L+L-1 : c*L].
- R update per CLK edge. Priority is SSEL > HOLD > capture:
  - SSEL=1: each segment shifts toward its low index. R[c*L+L-1] <= SDIN[c]; R[i] <= R[i+1] within the segment.
  - SSEL=0, HOLD=1: R holds its value.
  - Otherwise: R <= DIN.
- SDOUT[c] = R[c*L], taken combinationally from the register. No input reaches SDOUT combinationally.
- Shadow register Q: Q <= R on any edge where UPD=1, including when SSEL=1. In that case Q takes the pre-shift R. Otherwise Q holds.
- QN = ~Q at all times.
- Shift counter:
  - SSEL=0: SHIFT_CNT <= 0.
  - SSEL=1 and SHIFT_CNT<L: SHIFT_CNT increments.
  - SSEL=1 and SHIFT_CNT=L: SHIFT_CNT holds (saturates).
- SDONE is registered. It is 1 for exactly the cycle after the edge on which SHIFT_CNT goes from L-1 to L. It does not re-pulse while SHIFT_CNT stays saturated at L; a new pulse needs SSEL to drop first.
- L=1 is legal: SDONE pulses after the first shift cycle.

## Timing
- Reset (RSTB=0, asynchronous, no clock needed):
  - R=RST_VAL, Q=RST_VAL, QN=~RST_VAL.
  - SDOUT reflects RST_VAL.
  - SHIFT_CNT=0, SDONE=0.
- Reset asserted mid-shift aborts the shift immediately; no SDONE is issued.
- Release of RSTB is synchronised externally. The first active edge after release operates normally.
- Latency: DIN→R 1 cycle; R→Q 1 cycle after UPD; DIN→Q at least 2 cycles; SDIN→SDOUT L cycles.
- Dropping SSEL for one cycle mid-shift clears the count. SDONE then requires L fresh consecutive shift cycles.

## Structure
- Shared package `scan_pkg`:
  - Function seg_len(WIDTH, CHAINS).
  - Function cnt_width(L).
  - Elaboration check that WIDTH % CHAINS == 0 and CHAINS ≥ 1; the check fails compile otherwise.
- Sub-module `scan_seg`: one L-bit segment with capture, hold and shift. Instantiate it CHAINS times via generate.
- The shadow register and shift counter/SDONE stay in the top.

## Test plan
All scenarios use WIDTH=8, CHAINS=2, L=4, RST_VAL=0.

1. Reset: RSTB=0 with no clock → Q=8'h00, QN=8'hFF, SDOUT=2'b00, SHIFT_CNT=0, SDONE=0.
2. Capture then update:
   - DIN=8'hA5, SSEL=0, HOLD=0 for one edge → Q still 8'h00.
   - Next edge with UPD=1 → Q=8'hA5, QN=8'h5A.
   - HOLD=1 with DIN=8'h00 → R stays 8'hA5.
3. Full shift:
   - Start from R=8'hA5. SSEL=1, SDIN=2'b11 for 4 edges.
   - SDOUT[0] sequence 1,0,1,0; SDOUT[1] sequence 0,1,0,1.
   - R=8'hFF at the end; SHIFT_CNT=4; SDONE=1 for one cycle; Q unchanged 8'hA5.
4. Interrupted shift:
   - SSEL=1 for 2 edges, SSEL=0 for 1 edge, then SSEL=1 for 4 edges.
   - SHIFT_CNT returns to 0 at the break. SDONE pulses only after the 4th post-break edge.
   - Holding SSEL=1 for 3 further edges keeps SHIFT_CNT=4 with no second pulse.
5. Reset mid-shift: after 2 shift edges, pulse RSTB=0 between edges → R, Q, SHIFT_CNT clear immediately; no SDONE.
6. Simultaneous UPD and SSEL: with R=8'h3C, apply one edge with SSEL=1, UPD=1, SDIN=2'b00 → Q=8'h3C (pre-shift value) and R=8'h16.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared sizing helpers for the scan register bank.
// Pure elaboration-time functions, no logic.
// No flow control.
package scan_pkg;

    // Length of one scan segment.
    function automatic int seg_len(input int width, input int chains);
        return (chains > 0) ? (width / chains) : 0;
    endfunction

    // Width of a counter that must reach the value l.
    function automatic int cnt_width(input int l);
        return (l < 1) ? 1 : $clog2(l + 1);
    endfunction

    // Legal bank shape: at least one chain, and equal-length segments.
    function automatic bit cfg_ok(input int width, input int chains);
        return (chains >= 1) && (width >= chains) && ((width % chains) == 0);
    endfunction

endpackage

// File: rtl/scan_reg_bank_if.sv
// Functional and scan signal bundle for scan_reg_bank.
// Plain wires, no added latency.
// No flow control: the bank accepts inputs on every clock edge.
interface scan_reg_bank_if
    import scan_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHAINS = 2
);
    localparam int L  = seg_len(WIDTH, CHAINS);
    localparam int CW = cnt_width(L);

    logic [WIDTH-1:0]  DIN;
    logic [CHAINS-1:0] SDIN;
    logic              SSEL;
    logic              HOLD;
    logic              UPD;
    logic [WIDTH-1:0]  Q;
    logic [WIDTH-1:0]  QN;
    logic [CHAINS-1:0] SDOUT;
    logic [CW-1:0]     SHIFT_CNT;
    logic              SDONE;

    modport master (
        output DIN, SDIN, SSEL, HOLD, UPD,
        input  Q, QN, SDOUT, SHIFT_CNT, SDONE
    );

    modport slave (
        input  DIN, SDIN, SSEL, HOLD, UPD,
        output Q, QN, SDOUT, SHIFT_CNT, SDONE
    );
endinterface

// File: rtl/scan_seg.sv
// One scan segment: capture, hold or shift toward bit 0.
// Register updates 1 cycle after inputs; scan-out is bit 0 of the register.
// No flow control: shift has priority over hold, hold over capture.
module scan_seg #(
    parameter int           L       = 4,
    parameter logic [L-1:0] RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic [L-1:0] i_din,
    input  logic         i_sdin,
    input  logic         i_ssel,
    input  logic         i_hold,
    output logic [L-1:0] o_r,
    output logic         o_sdout
);
    logic [L-1:0] r_bits;
    logic [L-1:0] w_shift;

    // Shifted value: new bit enters at the top, bit 0 falls out.
    generate
        if (L == 1) begin : g_one
            assign w_shift = i_sdin;
        end else begin : g_many
            assign w_shift = {i_sdin, r_bits[L-1:1]};
        end
    endgenerate

    // Segment register with shift > hold > capture priority.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_bits <= RST_VAL;
        end else if (i_ssel) begin
            r_bits <= w_shift;
        end else if (!i_hold) begin
            r_bits <= i_din;
        end
    end

    assign o_r     = r_bits;
    assign o_sdout = r_bits[0];
endmodule

// File: rtl/scan_reg_bank.sv
// Multi-chain scan register bank with shadow output and shift-complete flag.
// DIN->capture 1 cycle, capture->Q 1 cycle after UPD; SDONE 1 cycle after the L-th shift.
// No flow control: every edge acts on the current mode inputs.
module scan_reg_bank
    import scan_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               CHAINS  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTB,
    scan_reg_bank_if.slave   bus
);
    localparam int            L    = seg_len(WIDTH, CHAINS);
    localparam int            CW   = cnt_width(L);
    localparam logic [CW-1:0] LMAX = CW'(L);

    // Reject bank shapes that cannot be split into equal segments.
    generate
        if (!cfg_ok(WIDTH, CHAINS)) begin : g_bad_cfg
            $error("scan_reg_bank: WIDTH must be a non-zero multiple of CHAINS");
        end
    endgenerate

    logic [WIDTH-1:0]  w_r;
    logic [CHAINS-1:0] w_sdout;
    logic [WIDTH-1:0]  r_q;
    logic [CW-1:0]     r_cnt;
    logic              r_sdone;

    generate
        for (genvar c = 0; c < CHAINS; c++) begin : g_seg
            scan_seg #(
                .L       (L),
                .RST_VAL (RST_VAL[c*L +: L])
            ) u_seg (
                .CLK     (CLK),
                .RSTB    (RSTB),
                .i_din   (bus.DIN[c*L +: L]),
                .i_sdin  (bus.SDIN[c]),
                .i_ssel  (bus.SSEL),
                .i_hold  (bus.HOLD),
                .o_r     (w_r[c*L +: L]),
                .o_sdout (w_sdout[c])
            );
        end
    endgenerate

    // Shadow register samples the pre-edge capture value, even mid-shift.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_q <= RST_VAL;
        end else if (bus.UPD) begin
            r_q <= w_r;
        end
    end

    // Consecutive-shift counter saturating at L; SDONE fires only on the L-1 -> L step.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_cnt   <= '0;
            r_sdone <= 1'b0;
        end else if (bus.SSEL) begin
            if (r_cnt != LMAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_sdone <= (r_cnt == LMAX - 1'b1);
        end else begin
            r_cnt   <= '0;
            r_sdone <= 1'b0;
        end
    end

    assign bus.Q         = r_q;
    assign bus.QN        = ~r_q;
    assign bus.SDOUT     = w_sdout;
    assign bus.SHIFT_CNT = r_cnt;
    assign bus.SDONE     = r_sdone;
endmodule

// File: tb/tb_scan_reg_bank.sv
// Self-checking bench for scan_reg_bank (WIDTH=8, CHAINS=2, L=4).
// Inputs driven #1 after the rising edge; outputs sampled #1 after it.
// Bank has no backpressure; every step is one clock edge.
module tb_scan_reg_bank;
    localparam int W  = 8;
    localparam int C  = 2;
    localparam int L  = W / C;
    localparam int CW = 3;

    logic CLK;
    logic RSTB;

    scan_reg_bank_if #(.WIDTH(W), .CHAINS(C)) bus ();

    scan_reg_bank #(.WIDTH(W), .CHAINS(C), .RST_VAL('0)) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural reference state.
    logic [W-1:0] m_r;
    logic [W-1:0] m_q;
    int           m_cnt;
    logic         m_done;

    int n_chk;
    int n_pass;

    logic [21:0] obs;
    assign obs = {bus.Q, bus.QN, bus.SDOUT, bus.SHIFT_CNT, bus.SDONE};

    function automatic logic [21:0] model_vec();
        logic [C-1:0] sd;
        for (int c = 0; c < C; c++) sd[c] = m_r[c*L];
        return {m_q, ~m_q, sd, CW'(m_cnt), m_done};
    endfunction

    task automatic model_reset();
        m_r = '0; m_q = '0; m_cnt = 0; m_done = 1'b0;
    endtask

    // Drive one edge worth of inputs, advance the model, settle past the edge.
    task automatic step(input logic [W-1:0] din, input logic [C-1:0] sdin,
                        input logic ssel, input logic hold, input logic upd);
        int           seg;
        logic [W-1:0] nr;
        bus.DIN = din; bus.SDIN = sdin; bus.SSEL = ssel; bus.HOLD = hold; bus.UPD = upd;
        @(posedge CLK);
        if (ssel) begin
            nr = '0;
            for (int c = 0; c < C; c++) begin
                seg = (int'(m_r) >> (c*L)) & ((1 << L) - 1);
                seg = (seg >> 1) + (int'(sdin[c]) << (L-1));
                nr  = nr | W'(seg << (c*L));
            end
        end else if (hold) begin
            nr = m_r;
        end else begin
            nr = din;
        end
        if (upd) m_q = m_r;
        m_done = ssel && (m_cnt == L-1);
        m_cnt  = ssel ? ((m_cnt < L) ? m_cnt + 1 : L) : 0;
        m_r    = nr;
        #1;
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        bus.DIN = '0; bus.SDIN = '0; bus.SSEL = 0; bus.HOLD = 0; bus.UPD = 0;
        model_reset();
        #3;
        n_chk++;
        if (obs !== {8'h00, 8'hFF, 2'b00, 3'd0, 1'b0})
            $display("FAIL reset_state got=%h want=%h", obs, {8'h00, 8'hFF, 2'b00, 3'd0, 1'b0});
        else n_pass++;
        @(negedge CLK);
        RSTB = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_capture_update();
        step(8'hA5, 2'b00, 0, 0, 0);
        n_chk++;
        if (bus.Q !== 8'h00) $display("FAIL cap_no_upd got=%h want=00", bus.Q); else n_pass++;
        step(8'hA5, 2'b00, 0, 0, 1);
        n_chk++;
        if ({bus.Q, bus.QN} !== 16'hA55A) $display("FAIL cap_upd got=%h want=a55a", {bus.Q, bus.QN}); else n_pass++;
        step(8'h00, 2'b00, 0, 1, 0);
        step(8'h00, 2'b00, 0, 1, 1);
        n_chk++;
        if (bus.Q !== 8'hA5) $display("FAIL hold_keeps got=%h want=a5", bus.Q); else n_pass++;
        n_chk++;
        if (obs !== model_vec()) $display("FAIL cap_model got=%h want=%h", obs, model_vec()); else n_pass++;
    endtask

    task automatic test_full_shift();
        logic [1:0] exp_sd [4];
        exp_sd = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (bus.SDOUT !== exp_sd[k]) $display("FAIL shift_sdout_%0d got=%b want=%b", k, bus.SDOUT, exp_sd[k]);
            else n_pass++;
            step(8'h00, 2'b11, 1, 0, 0);
        end
        n_chk++;
        if ({bus.SHIFT_CNT, bus.SDONE, bus.Q} !== {3'd4, 1'b1, 8'hA5})
            $display("FAIL shift_end got=%h want=%h", {bus.SHIFT_CNT, bus.SDONE, bus.Q}, {3'd4, 1'b1, 8'hA5});
        else n_pass++;
        step(8'h00, 2'b00, 0, 1, 1);
        n_chk++;
        if ({bus.Q, bus.SDONE} !== {8'hFF, 1'b0})
            $display("FAIL shift_result got=%h want=%h", {bus.Q, bus.SDONE}, {8'hFF, 1'b0});
        else n_pass++;
    endtask

    task automatic test_interrupted_shift();
        step(8'h00, 2'b10, 1, 0, 0);
        step(8'h00, 2'b01, 1, 0, 0);
        step(8'h00, 2'b00, 0, 1, 0);
        n_chk++;
        if (bus.SHIFT_CNT !== 3'd0) $display("FAIL break_cnt got=%0d want=0", bus.SHIFT_CNT); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            step(W'($urandom), C'($urandom), 1, 0, 0);
            n_chk++;
            if ({bus.SHIFT_CNT, bus.SDONE} !== {CW'(k), (k == 4)})
                $display("FAIL restart_%0d got=%h want=%h", k, {bus.SHIFT_CNT, bus.SDONE}, {CW'(k), (k == 4)});
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            step(W'($urandom), C'($urandom), 1, 0, 0);
            n_chk++;
            if ({bus.SHIFT_CNT, bus.SDONE} !== {3'd4, 1'b0})
                $display("FAIL saturate_%0d got=%h want=%h", k, {bus.SHIFT_CNT, bus.SDONE}, {3'd4, 1'b0});
            else n_pass++;
        end
        n_chk++;
        if (obs !== model_vec()) $display("FAIL interrupt_model got=%h want=%h", obs, model_vec()); else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        step(8'h5A, 2'b00, 0, 0, 1);
        step(8'h00, 2'b11, 1, 0, 1);
        step(8'h00, 2'b11, 1, 0, 0);
        @(negedge CLK);
        RSTB = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (obs !== {8'h00, 8'hFF, 2'b00, 3'd0, 1'b0})
            $display("FAIL mid_reset got=%h want=%h", obs, {8'h00, 8'hFF, 2'b00, 3'd0, 1'b0});
        else n_pass++;
        #1;
        RSTB = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step(8'h00, 2'b11, 1, 0, 0);
            n_chk++;
            if ({bus.SHIFT_CNT, bus.SDONE} !== {CW'(k), 1'b0})
                $display("FAIL post_reset_%0d got=%h want=%h", k, {bus.SHIFT_CNT, bus.SDONE}, {CW'(k), 1'b0});
            else n_pass++;
        end
    endtask

    task automatic test_upd_during_shift();
        step(8'h3C, 2'b00, 0, 0, 0);
        step(8'h00, 2'b00, 1, 0, 1);
        n_chk++;
        if (bus.Q !== 8'h3C) $display("FAIL upd_shift_pre got=%h want=3c", bus.Q); else n_pass++;
        step(8'h00, 2'b00, 0, 1, 1);
        n_chk++;
        if (bus.Q !== 8'h16) $display("FAIL upd_shift_post got=%h want=16", bus.Q); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(W'($urandom), C'($urandom), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            n_chk++;
            if (obs !== model_vec()) $display("FAIL random_%0d got=%h want=%h", i, obs, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_capture_update();
        test_full_shift();
        test_interrupted_shift();
        test_reset_mid_shift();
        test_upd_during_shift();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
